array_multiplier: RTL and testbench
===================================

Name: array_multiplier

Overview:
- Unsigned 4x4 array multiplier (AND partial products reduced by a ripple array of full/half adders) with a registered 8-bit product.
- Leaf arithmetic block used by the top-level datapath wrapper.
- One clock; reset is asynchronous and active-high.
- Single pipeline register on the output; the adder array itself is purely combinational.

Parameters:
- WIDTH, 4, operand width in bits. Product width is 2*WIDTH. Only 4 is required to be verified; the RTL is written generically with generate loops.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- a  input  WIDTH (4)  unsigned multiplicand
- b  input  WIDTH (4)  unsigned multiplier
- p  output  2*WIDTH (8)  registered unsigned product a*b

Behaviour:
- Reset:
  - rst asserted drives p to 8'h00 immediately, without waiting for a clock edge.
  - p holds 0 while rst is high.
  - Reset has priority over any clock edge.
- Function: on each rising clk edge with rst low, p <= a*b, computed exactly as an unsigned value.
  - The result always fits in 8 bits (max 15*15 = 225 = 8'b1110_0001), so no overflow or truncation is possible.
- Latency: 1 cycle. Inputs applied before edge N appear on p after edge N and stay stable until the next edge.
  - No enable and no handshake: the block computes on every cycle.
- Array structure, 4x4 case:
  - Partial products pp[i][j] = a[j] & b[i].
  - Row 0 passes through. Rows 1..3 each add the shifted partial-product row to the running sum using a chain of full adders, with carry rippling within the row.
  - The carry-out of each row becomes the MSB of that row's sum.
  - p[0] = pp[0][0]; p[i] = LSB of row i sum; p[7:4] = upper bits of the final row.
  - Behavioural "*" is not permitted in the datapath.
- Mid-operation reset: asserting rst between edges clears p at once. After deassertion, the first rising edge loads the product of the current inputs.
- X handling: no requirement. Inputs are assumed driven; the bench drives all bits.
- No internal state other than the p register.

Decomposition:
- Package array_mult_pkg:
  - localparam MULT_W = 4
  - localparam PROD_W = 2*MULT_W
  - typedefs operand_t (logic [MULT_W-1:0]) and product_t (logic [PROD_W-1:0])
- Sub-module array_mult_fa: 1-bit full adder with ports a, b, cin, sum, cout. It is instantiated (WIDTH-1)*WIDTH times in generate loops. A half adder is formed by tying cin to 0.
- Top level contains the partial-product AND grid, the generate-built adder rows, and the output register.

Test Plan:
- Reset:
  - Assert rst with a=4'hF, b=4'hF and no clock edge → p=8'h00 immediately.
  - Hold rst across 3 edges → p stays 8'h00.
- Squares sweep: for i=0..15, drive a=b=i and wait one edge each. Required p values in order: 0, 1, 4, 9, 16, 25, 36, 49, 64, 81, 100, 121, 144, 169, 196, 225. Check specifically 7*7 → 8'b0011_0001 and 15*15 → 8'b1110_0001.
- Exhaustive: all 256 (a,b) pairs → p == a*b one cycle later; also check commutativity, e.g. a=3,b=12 and a=12,b=3 → 8'd36.
- Latency: a=5, b=6 at edge N, then a=2, b=2 at edge N+1 → p=30 after N, p=4 after N+1; p unchanged between edges.
- Mid-operation reset: p=225, pulse rst between edges → p=0 immediately. Release rst with a=9, b=10 → p=90 after the next edge.
- Zero/identity: a=0, b=15 → 0; a=1, b=13 → 13; a=15, b=1 → 15.

Source files
------------

// File: rtl/array_mult_pkg.sv
// Shared widths and operand/product types for the unsigned array multiplier.
package array_mult_pkg;

  localparam int MULT_W = 4;
  localparam int PROD_W = 2 * MULT_W;

  typedef logic [MULT_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] product_t;

endpackage : array_mult_pkg

// File: rtl/array_mult_fa.sv
// One-bit full adder cell of the multiplier array; tie cin low for a half adder.
module array_mult_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : array_mult_fa

// File: rtl/array_multiplier.sv
// Unsigned WIDTH x WIDTH ripple array multiplier with a single registered product.
module array_multiplier
  import array_mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  logic [WIDTH-1:0]   pp      [WIDTH];
  logic [WIDTH:0]     row_sum [WIDTH];
  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH-1:0] p_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_bit
      assign pp[i][j] = a[j] & b[i];
    end
  end

  assign row_sum[0] = {1'b0, pp[0]};

  // Row i adds its partial products to the previous sum shifted right by one;
  // the row carry-out becomes the MSB of that row's sum.
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    assign acc      = row_sum[i-1][WIDTH:1];
    assign carry[0] = 1'b0;

    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
      array_mult_fa u_fa (
        .a    (acc[j]),
        .b    (pp[i][j]),
        .cin  (carry[j]),
        .sum  (sum[j]),
        .cout (carry[j+1])
      );
    end

    assign row_sum[i] = {carry[WIDTH], sum};
  end

  always_comb begin
    p_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p_d[i] = row_sum[i][0];
    end
    p_d[2*WIDTH-1:WIDTH] = row_sum[WIDTH-1][WIDTH:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule : array_multiplier

// File: tb/tb_array_multiplier.sv
// Directed self-checking bench for the 4x4 registered array multiplier.
module tb_array_multiplier;
  import array_mult_pkg::*;

  logic     clk;
  logic     rst;
  operand_t a;
  operand_t b;
  product_t p;

  int tests_run;
  int tests_failed;

  localparam product_t SQUARES [16] = '{
    8'd0,   8'd1,   8'd4,   8'd9,   8'd16,  8'd25,  8'd36,  8'd49,
    8'd64,  8'd81,  8'd100, 8'd121, 8'd144, 8'd169, 8'd196, 8'd225
  };

  array_multiplier #(.WIDTH(MULT_W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .p   (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input product_t observed, input product_t expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d (0x%02h), expected %0d (0x%02h)",
             tag, observed, observed, expected, expected);
    end
  endtask

  // Drive operands away from the active edge, then sample just after it.
  task automatic apply_stimulus(input operand_t av, input operand_t bv);
    @(negedge clk);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    a   = 4'hF;
    b   = 4'hF;
    rst = 1'b0;

    #2;
    rst = 1'b1;
    #1;
    check_output("reset_immediate", p, 8'h00);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("reset_hold_%0d", k), p, 8'h00);
    end

    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(4'd15, 4'd15);
    check_output("first_after_reset_15x15", p, 8'd225);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(operand_t'(i), operand_t'(i));
      check_output($sformatf("square_%0d", i), p, SQUARES[i]);
      if (i == 7)  check_output("square_7_bits", p, 8'b0011_0001);
      if (i == 15) check_output("square_15_bits", p, 8'b1110_0001);
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        apply_stimulus(operand_t'(i), operand_t'(j));
        check_output($sformatf("exh_%0dx%0d", i, j), p, product_t'(i * j));
      end
    end

    apply_stimulus(4'd3, 4'd12);
    check_output("commute_3x12", p, 8'd36);
    apply_stimulus(4'd12, 4'd3);
    check_output("commute_12x3", p, 8'd36);

    apply_stimulus(4'd5, 4'd6);
    check_output("latency_5x6", p, 8'd30);
    @(negedge clk);
    a = 4'd2;
    b = 4'd2;
    #1;
    check_output("latency_hold_between_edges", p, 8'd30);
    @(posedge clk);
    #1;
    check_output("latency_2x2", p, 8'd4);

    apply_stimulus(4'd15, 4'd15);
    check_output("pre_midreset_225", p, 8'd225);
    #2;
    rst = 1'b1;
    #1;
    check_output("midreset_immediate", p, 8'h00);
    @(posedge clk);
    #1;
    check_output("midreset_held_over_edge", p, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    a   = 4'd9;
    b   = 4'd10;
    #1;
    check_output("midreset_released_no_edge", p, 8'h00);
    @(posedge clk);
    #1;
    check_output("after_release_9x10", p, 8'd90);

    apply_stimulus(4'd0, 4'd15);
    check_output("zero_0x15", p, 8'd0);
    apply_stimulus(4'd1, 4'd13);
    check_output("identity_1x13", p, 8'd13);
    apply_stimulus(4'd15, 4'd1);
    check_output("identity_15x1", p, 8'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_array_multiplier
